// File: rtl/ysyx_lsu_sq.sv
// rtl/ysyx_lsu_sq.sv - commit-side store queue draining to a write bus
// Circular FIFO of committed stores with youngest-match load forwarding.
module ysyx_lsu_sq #(
   parameter int XLEN    = 32,
   parameter int SQ_SIZE = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic                      in_store,
   input  logic [4:0]                in_alu,
   input  logic [XLEN-1:0]           in_waddr,
   input  logic [XLEN-1:0]           in_wdata,
   output logic                      in_ready,
   output logic                      awvalid,
   output logic [XLEN-1:0]           awaddr,
   output logic                      wvalid,
   output logic [XLEN-1:0]           wdata,
   output logic [7:0]                wstrb,
   input  logic                      wready,
   input  logic [XLEN-1:0]           fwd_addr,
   output logic                      fwd_hit,
   output logic                      fwd_word,
   output logic [XLEN-1:0]           fwd_data,
   output logic                      sq_empty,
   output logic [$clog2(SQ_SIZE):0]  sq_count
);

   localparam int PW = $clog2(SQ_SIZE);
   localparam int CW = PW + 1;

   // Only the size field of alu matters once a store is committed.
   logic [1:0]      alu_q  [SQ_SIZE];
   logic [XLEN-1:0] addr_q [SQ_SIZE];
   logic [XLEN-1:0] data_q [SQ_SIZE];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [PW-1:0] idx;
   logic          enq;
   logic          deq;
   logic          unused_alu;

   assign unused_alu = ^in_alu[4:2];

   assign in_ready = (count < CW'(SQ_SIZE));
   assign sq_empty = (count == '0);
   assign sq_count = count;
   assign enq      = in_valid & in_store & in_ready;
   assign deq      = wready & ~sq_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < SQ_SIZE; i++) begin
            alu_q[i]  <= '0;
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (enq) begin
            alu_q[tail]  <= in_alu[1:0];
            addr_q[tail] <= in_waddr;
            data_q[tail] <= in_wdata;
            tail         <= tail + 1'b1;
         end
         if (deq) begin
            head <= head + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign awvalid = ~sq_empty;
   assign wvalid  = ~sq_empty;
   assign awaddr  = addr_q[head];
   assign wdata   = data_q[head];

   always_comb begin
      wstrb = 8'h0F;
      case (alu_q[head])
         2'b00:   wstrb = 8'h01;
         2'b01:   wstrb = 8'h03;
         default: wstrb = 8'h0F;
      endcase
   end

   // Walk oldest to youngest so the last match (closest to tail) wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_word = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < SQ_SIZE; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (addr_q[idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_word = alu_q[idx][1];
            fwd_data = data_q[idx];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_lsu_sq.sv
// tb/tb_ysyx_lsu_sq.sv - scoreboard bench for ysyx_lsu_sq
// Stimulus pushes expected bus writes; a negedge monitor pops on each handshake.
module tb_ysyx_lsu_sq;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_store;
   logic [4:0]  in_alu;
   logic [31:0] in_waddr;
   logic [31:0] in_wdata;
   logic        in_ready;
   logic        awvalid;
   logic [31:0] awaddr;
   logic        wvalid;
   logic [31:0] wdata;
   logic [7:0]  wstrb;
   logic        wready;
   logic [31:0] fwd_addr;
   logic        fwd_hit;
   logic        fwd_word;
   logic [31:0] fwd_data;
   logic        sq_empty;
   logic [2:0]  sq_count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  strb;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   ysyx_lsu_sq #(.XLEN(32), .SQ_SIZE(4)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_store(in_store), .in_alu(in_alu),
      .in_waddr(in_waddr), .in_wdata(in_wdata), .in_ready(in_ready),
      .awvalid(awvalid), .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
      .wstrb(wstrb), .wready(wready),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_word(fwd_word),
      .fwd_data(fwd_data), .sq_empty(sq_empty), .sq_count(sq_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [7:0] strb_of(input logic [4:0] alu);
      case (alu[1:0])
         2'b00:   return 8'h01;
         2'b01:   return 8'h03;
         default: return 8'h0F;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a; w.data = d; w.strb = strb_of(alu);
      exp_q.push_back(w);
   endtask

   task automatic set_in(input logic v, input logic s, input logic [4:0] alu,
                         input logic [31:0] a, input logic [31:0] d);
      in_valid = v; in_store = s; in_alu = alu; in_waddr = a; in_wdata = d;
   endtask

   // Single enqueue cycle that is expected to be accepted.
   task automatic enq(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] d);
      set_in(1'b1, 1'b1, alu, a, d);
      push(alu, a, d);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      wready = 1'b1;
      for (k = 0; k < 20 && !sq_empty; k++) step();
      wready = 1'b0;
      check("drain_done", {63'd0, sq_empty}, 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   always @(negedge clock) begin
      if (!reset && awvalid && wready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {32'd0, awaddr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("bus_awaddr", {32'd0, awaddr}, {32'd0, w.addr});
            check("bus_wdata",  {32'd0, wdata},  {32'd0, w.data});
            check("bus_wstrb",  {56'd0, wstrb},  {56'd0, w.strb});
            check("bus_wvalid", {63'd0, wvalid}, 64'd1);
         end
      end
   end

   initial begin
      reset = 1'b1; wready = 1'b0; fwd_addr = 32'h0;
      set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      step();
      do_reset();

      // Reset values
      check("rst_awvalid",  {63'd0, awvalid},  64'd0);
      check("rst_wvalid",   {63'd0, wvalid},   64'd0);
      check("rst_awaddr",   {32'd0, awaddr},   64'd0);
      check("rst_wdata",    {32'd0, wdata},    64'd0);
      check("rst_wstrb",    {56'd0, wstrb},    64'h01);
      check("rst_fwd_hit",  {63'd0, fwd_hit},  64'd0);
      check("rst_sq_empty", {63'd0, sq_empty}, 64'd1);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_sq_count", {61'd0, sq_count}, 64'd0);

      // Single word store, bus stalls 3 cycles
      set_in(1'b1, 1'b1, 5'd2, 32'h8000_0010, 32'hDEAD_BEEF);
      push(5'd2, 32'h8000_0010, 32'hDEAD_BEEF);
      check("no_comb_aw", {63'd0, awvalid}, 64'd0);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("hold_awvalid", {63'd0, awvalid}, 64'd1);
         check("hold_awaddr",  {32'd0, awaddr},  64'h8000_0010);
         check("hold_wstrb",   {56'd0, wstrb},   64'h0F);
         step();
      end
      check("hold_awvalid4", {63'd0, awvalid}, 64'd1);
      wready = 1'b1;
      step();
      wready = 1'b0;
      check("empty_after_w", {63'd0, sq_empty}, 64'd1);

      // Five back-to-back stores into depth 4 with the bus stalled
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b1, 5'd2, 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
         check("fill_in_ready", {63'd0, in_ready}, (i < 4) ? 64'd1 : 64'd0);
         if (i < 4) push(5'd2, 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
         step();
      end
      in_valid = 1'b0;
      check("full_count", {61'd0, sq_count}, 64'd4);
      wready = 1'b1;
      check("full_no_ready", {63'd0, in_ready}, 64'd0);
      step();
      wready = 1'b0;
      check("ready_back", {63'd0, in_ready}, 64'd1);
      check("count_3",    {61'd0, sq_count}, 64'd3);

      // Refill, then enqueue and dequeue together while full
      enq(5'd1, 32'h1010, 32'h0000_B0B0);
      check("refull_count", {61'd0, sq_count}, 64'd4);
      set_in(1'b1, 1'b1, 5'd0, 32'h1020, 32'h0000_00CC);
      wready = 1'b1;
      check("full_deq_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      in_valid = 1'b0; wready = 1'b0;
      check("full_deq_count", {61'd0, sq_count}, 64'd3);
      drain();

      // Ten stores streaming through with the bus always ready (pointer wrap)
      wready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'b1, 5'(i % 4), 32'h2000 + 32'(i), 32'h5500_0000 + 32'(i * 17));
         push(5'(i % 4), 32'h2000 + 32'(i), 32'h5500_0000 + 32'(i * 17));
         step();
      end
      in_valid = 1'b0;
      drain();

      // Forwarding
      do_reset();
      enq(5'd0, 32'h100, 32'h11);
      enq(5'd2, 32'h100, 32'h2233_4455);
      enq(5'd1, 32'h200, 32'h99);
      fwd_addr = 32'h100; #1;
      check("fwd100_hit",  {63'd0, fwd_hit},  64'd1);
      check("fwd100_data", {32'd0, fwd_data}, 64'h2233_4455);
      check("fwd100_word", {63'd0, fwd_word}, 64'd1);
      fwd_addr = 32'h104; #1;
      check("fwd104_hit",  {63'd0, fwd_hit},  64'd0);
      check("fwd104_data", {32'd0, fwd_data}, 64'd0);
      check("fwd104_word", {63'd0, fwd_word}, 64'd0);
      fwd_addr = 32'h200; #1;
      check("fwd200_data", {32'd0, fwd_data}, 64'h99);
      check("fwd200_word", {63'd0, fwd_word}, 64'd0);
      set_in(1'b1, 1'b1, 5'd2, 32'h300, 32'h3333);
      push(5'd2, 32'h300, 32'h3333);
      fwd_addr = 32'h300; #1;
      check("fwd_same_cycle", {63'd0, fwd_hit}, 64'd0);
      step();
      in_valid = 1'b0;
      check("fwd_next_cycle", {63'd0, fwd_hit}, 64'd1);
      fwd_addr = 32'h100;
      wready = 1'b1; #1;
      check("fwd_head_in_flight", {63'd0, fwd_hit}, 64'd1);
      step();
      wready = 1'b0;
      check("fwd_after_deq", {32'd0, fwd_data}, 64'h2233_4455);

      // Reset with three queued entries and the bus ready abandons them
      check("pre_rst_count", {61'd0, sq_count}, 64'd3);
      reset = 1'b1; wready = 1'b1;
      set_in(1'b1, 1'b1, 5'd2, 32'h400, 32'h4444);
      step();
      reset = 1'b0; wready = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      check("rst_q_count",    {61'd0, sq_count}, 64'd0);
      check("rst_q_awvalid",  {63'd0, awvalid},  64'd0);
      check("rst_q_in_ready", {63'd0, in_ready}, 64'd1);

      // Non-store request ignored, then a half store
      set_in(1'b1, 1'b0, 5'd1, 32'h40, 32'hAABB_CCDD);
      step();
      in_valid = 1'b0;
      check("nostore_count", {61'd0, sq_count}, 64'd0);
      check("nostore_empty", {63'd0, sq_empty}, 64'd1);
      enq(5'd1, 32'h40, 32'hAABB_CCDD);
      check("half_wstrb", {56'd0, wstrb}, 64'h03);
      drain();

      step();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
